// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier sequencer slice.
//   OP_W            operand width fed to top_multiplier
//   PP_W            product width returned by top_multiplier
//   DEF_MULT_CYCLES default compute budget, in cycles of mult_start
//   ST_*            sequencer FSM state encoding
package mult_pkg;

  localparam int OP_W            = 8;
  localparam int PP_W            = 16;
  localparam int DEF_MULT_CYCLES = 18;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/mult_acc.sv
// Running accumulator for MAC-style use of the multiplier.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   clear       clears the sum and the overflow flag
//   add_en      adds the zero-extended addend this edge
//   addend      product to accumulate
//   acc         running sum, wraps modulo 2^ACC_W
//   ovf         sticky flag, set when an add carries out of the top bit
// When clear and add_en coincide, the clear applies first and the addend
// becomes the new sum.
module mult_acc
  import mult_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add_en,
  input  logic [PP_W-1:0]  addend,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum;

  // One extra bit on the sum captures the carry out of the accumulator.
  always_comb begin
    base = clear ? '0 : acc;
    sum  = {1'b0, base} + {{(ACC_W + 1 - PP_W){1'b0}}, addend};
  end

  // NOTE: reset is sampled inside the clocked block, so it only takes
  // effect on a rising edge; there is no asynchronous path.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (add_en) begin
      acc <= sum[ACC_W-1:0];
      ovf <= (clear ? 1'b0 : ovf) | sum[ACC_W];
    end else if (clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Operand sequencer and result collector wrapped around top_multiplier.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake; in_a, in_b, acc_en ride with it
//   acc_clear             clears accumulator and overflow flag
//   mult_reset/start/a/b  drive top_multiplier; mult_pp is its product
//   res_valid/res_ready   result handshake; res_data is the captured product
//   acc_out, acc_ovf      running accumulator and sticky wrap flag
//   busy                  high whenever the sequencer is not idle
// One operation: IDLE (accept) -> LOAD (pulse multiplier reset) -> RUN
// (mult_start for MULT_CYCLES cycles, capture pp on the last) -> HOLD
// (present result until res_ready) -> IDLE.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int ACC_W       = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             acc_en,
  input  logic             acc_clear,
  output logic             mult_reset,
  output logic             mult_start,
  output logic [OP_W-1:0]  mult_a,
  output logic [OP_W-1:0]  mult_b,
  input  logic [PP_W-1:0]  mult_pp,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [PP_W-1:0]  res_data,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic             busy
);

  localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             acc_en_q;
  logic             run_done;

  // The last RUN cycle is the one whose closing edge samples mult_pp.
  assign run_done   = (state == ST_RUN) && (cnt == CNT_LAST);

  assign in_ready   = (state == ST_IDLE) && !reset;
  assign mult_reset = reset || (state == ST_LOAD);
  assign mult_start = (state == ST_RUN);
  assign res_valid  = (state == ST_HOLD);
  assign busy       = (state != ST_IDLE);

  // NOTE: every register here uses non-blocking assignment so all state
  // updates on an edge see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mult_a   <= '0;
      mult_b   <= '0;
      acc_en_q <= 1'b0;
      res_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mult_a   <= in_a;
            mult_b   <= in_b;
            acc_en_q <= acc_en;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (run_done) begin
            res_data <= mult_pp;
            state    <= ST_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mult_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk    (clk),
    .reset  (reset),
    .clear  (acc_clear),
    .add_en (run_done && acc_en_q),
    .addend (mult_pp),
    .acc    (acc_out),
    .ovf    (acc_ovf)
  );

endmodule
